// File: rtl/count_store_reader.sv
// count_store_reader: buffers captured count values in a small FIFO and
// hands them one at a time to a downstream consumer over valid/ready.
// The output register holds the presented word; count excludes it.
`timescale 1ns/1ps
module count_store_reader #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              newclk_k,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    input  logic              clr_ovf
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    typedef enum logic {
        IDLE,
        PRESENT
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wptr_q, wptr_d;
    logic [ADDR_W-1:0]   rptr_q, rptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                ovf_q, ovf_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                full_w;
    logic                push;
    logic                drop;
    logic                load;

    // Full is taken from the registered count, so a pop in the same cycle
    // does not make room for a write that arrives while full.
    assign full_w = (count_q == DEPTH_C);
    assign push   = wr_en && !full_w;
    assign drop   = wr_en && full_w;

    // FIFO storage: data only, never reset.
    always_ff @(posedge newclk_k) begin
        if (push) begin
            mem_q[wptr_q] <= wr_data;
        end
    end

    // Read FSM: decides when the output register loads from the FIFO.
    always_comb begin
        state_d    = state_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        rptr_d     = rptr_q;
        load       = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    load       = 1'b1;
                    rd_data_d  = mem_q[rptr_q];
                    rptr_d     = rptr_q + ADDR_W'(1);
                    rd_valid_d = 1'b1;
                    state_d    = PRESENT;
                end
            end
            PRESENT: begin
                if (rd_ready) begin
                    if (count_q != '0) begin
                        // Back-to-back reload keeps one word per cycle.
                        load       = 1'b1;
                        rd_data_d  = mem_q[rptr_q];
                        rptr_d     = rptr_q + ADDR_W'(1);
                    end else begin
                        // rd_data keeps its last value once the buffer drains.
                        rd_valid_d = 1'b0;
                        state_d    = IDLE;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                rd_valid_d = 1'b0;
            end
        endcase
    end

    // Write pointer, occupancy and sticky overflow (set beats clear).
    always_comb begin
        wptr_d  = push ? (wptr_q + ADDR_W'(1)) : wptr_q;
        count_d = count_q;
        case ({push, load})
            2'b10:   count_d = count_q + (ADDR_W+1)'(1);
            2'b01:   count_d = count_q - (ADDR_W+1)'(1);
            default: count_d = count_q;
        endcase
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge newclk_k or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            ovf_q      <= ovf_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign count    = count_q;
    assign full     = full_w;
    assign empty    = (count_q == '0);
    assign overflow = ovf_q;

endmodule

// File: tb/tb_count_store_reader.sv
// Bench for count_store_reader: directed stimulus pushes expected words into
// a queue; a negedge monitor pops and compares on every accepted handshake.
`timescale 1ns/1ps
module tb_count_store_reader;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    logic              newclk_k = 1'b0;
    logic              rst_n;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_ready;
    logic              clr_ovf;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;
    logic              overflow;

    int tests = 0;
    int fails = 0;

    logic [DATA_W-1:0] exp_q [$];
    logic              stream_mode = 1'b0;

    // monitor state
    bit                hold_prev = 1'b0;
    logic [DATA_W-1:0] held      = '0;
    logic [DATA_W-1:0] exp_word;
    int                cyc       = 0;
    int                last_cyc  = 0;
    bit                seen      = 1'b0;

    count_store_reader #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) dut (
        .newclk_k(newclk_k),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_ready(rd_ready),
        .rd_valid(rd_valid),
        .rd_data (rd_data),
        .count   (count),
        .full    (full),
        .empty   (empty),
        .overflow(overflow),
        .clr_ovf (clr_ovf)
    );

    always #5 newclk_k = ~newclk_k;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge newclk_k);
        #1;
    endtask

    task automatic write_word(input logic [DATA_W-1:0] d, input bit accept);
        wr_en   = 1'b1;
        wr_data = d;
        if (accept) exp_q.push_back(d);
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic drain(input int maxc, input bit rnd);
        int k = 0;
        while ((rd_valid || exp_q.size() != 0) && k < maxc) begin
            rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            k++;
        end
        rd_ready = 1'b0;
        check("drain_words_left", exp_q.size(), 0);
        check("drain_rd_valid", rd_valid, 0);
    endtask

    // Scoreboard monitor: compares each accepted word, checks hold stability
    // and, while streaming, that accepted words arrive on consecutive cycles.
    initial begin
        forever begin
            @(negedge newclk_k);
            cyc++;
            if (rst_n && rd_valid) begin
                if (hold_prev) check("hold_stable", rd_data, held);
                if (rd_ready) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_word: got %0h, expected no word", rd_data);
                    end else begin
                        exp_word = exp_q.pop_front();
                        check("rd_data_order", rd_data, exp_word);
                    end
                    if (stream_mode) begin
                        if (seen) check("stream_gap", cyc - last_cyc, 1);
                        seen     = 1'b1;
                        last_cyc = cyc;
                    end
                    hold_prev = 1'b0;
                end else begin
                    hold_prev = 1'b1;
                    held      = rd_data;
                end
            end else begin
                hold_prev = 1'b0;
            end
            if (!stream_mode) seen = 1'b0;
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        wr_en    = 1'b0;
        wr_data  = '0;
        rd_ready = 1'b0;
        clr_ovf  = 1'b0;

        // Reset / idle
        repeat (3) tick();
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_overflow", overflow, 0);
        rst_n = 1'b1;
        tick();
        check("idle_rd_valid", rd_valid, 0);
        check("idle_empty", empty, 1);

        // Single word with latency and hold
        write_word(8'h2A, 1'b1);
        check("single_count_after_write", count, 1);
        check("single_not_yet_valid", rd_valid, 0);
        tick();
        check("single_valid", rd_valid, 1);
        check("single_data", rd_data, 8'h2A);
        check("single_count_loaded", count, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("single_hold_valid", rd_valid, 1);
            check("single_hold_data", rd_data, 8'h2A);
        end
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        check("single_valid_drop", rd_valid, 0);
        check("single_count_zero", count, 0);
        check("single_data_kept", rd_data, 8'h2A);

        // Streaming 1..20 with rd_ready held high
        stream_mode = 1'b1;
        rd_ready    = 1'b1;
        for (int i = 1; i <= 20; i++) write_word(8'(i), 1'b1);
        drain(10, 1'b0);
        check("stream_overflow", overflow, 0);
        stream_mode = 1'b0;

        // Fill and overflow: A9 is dropped
        rd_ready = 1'b0;
        for (int i = 0; i < 10; i++) write_word(8'hA0 + 8'(i), i < 9);
        check("fill_valid", rd_valid, 1);
        check("fill_data", rd_data, 8'hA0);
        check("fill_count", count, 8);
        check("fill_full", full, 1);
        check("fill_empty", empty, 0);
        check("fill_overflow", overflow, 1);

        // Write while full plus pop in the same cycle: write still dropped
        wr_en    = 1'b1;
        wr_data  = 8'hBB;
        rd_ready = 1'b1;
        tick();
        wr_en    = 1'b0;
        rd_ready = 1'b0;
        check("simul_count", count, 7);
        check("simul_overflow", overflow, 1);
        check("simul_full", full, 0);
        check("simul_data", rd_data, 8'hA1);

        write_word(8'hCC, 1'b1);
        check("refill_full", full, 1);

        // Clear together with a new drop: set wins
        clr_ovf = 1'b1;
        write_word(8'hDD, 1'b0);
        clr_ovf = 1'b0;
        check("clr_with_drop_overflow", overflow, 1);

        // Clear alone
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("clr_alone_overflow", overflow, 0);
        check("clr_alone_count", count, 8);

        drain(40, 1'b0);

        // Wrap-around: 3 rounds of 6 writes / 6 reads with random stalls
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 6; i++) begin
                rd_ready = 1'($urandom_range(0, 1));
                write_word(8'h40 + 8'(r * 6 + i), 1'b1);
            end
            drain(200, 1'b1);
        end
        check("wrap_overflow", overflow, 0);

        // Asynchronous reset mid-cycle with a full buffer and overflow set
        rd_ready = 1'b0;
        for (int i = 0; i < 10; i++) write_word(8'h60 + 8'(i), i < 9);
        check("pre_reset_overflow", overflow, 1);
        check("pre_reset_full", full, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_rd_valid", rd_valid, 0);
        check("async_rst_rd_data", rd_data, 0);
        check("async_rst_count", count, 0);
        check("async_rst_empty", empty, 1);
        check("async_rst_full", full, 0);
        check("async_rst_overflow", overflow, 0);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("post_rst_rd_valid", rd_valid, 0);
        check("post_rst_count", count, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
